// File: rtl/lsu_align_unit.sv
// Load/store alignment unit: turns one MEM-stage access into one or two
// aligned memory beats and returns the lane-aligned, extended load result.
module lsu_align_unit #(
  parameter int XLEN             = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_err
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int SW   = OFFW + 2;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t            state, nxt;
  logic              we_q, spans_q, resp_err_q;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   addr_q, wdata_q, rd0_q, resp_data_q;

  // request decode, evaluated on the raw request so the decision is ready at accept
  logic [OFFW-1:0]   req_off;
  logic [3:0]        req_size;
  logic              req_spans, req_legal, req_err;

  assign req_off   = req_addr[OFFW-1:0];
  assign req_size  = 4'd1 << req_funct3[1:0];
  assign req_spans = ({2'b00, req_off} + SW'(req_size)) > SW'(NB);

  always_comb begin
    req_legal = 1'b0;
    if (req_we) begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010: req_legal = 1'b1;
        3'b011:                 req_legal = (XLEN == 64);
        default:                req_legal = 1'b0;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_legal = 1'b1;
        3'b011, 3'b110:                         req_legal = (XLEN == 64);
        default:                                req_legal = 1'b0;
      endcase
    end
  end

  assign req_err = !req_legal || (req_spans && !ALLOW_MISALIGNED);

  // lane placement over a double-width window; the upper half feeds beat 1
  logic [OFFW-1:0]   off_q;
  logic [2*NB-1:0]   be_mask, be_full;
  logic [2*XLEN-1:0] w_full, r_cat;
  logic [XLEN-1:0]   base_addr, sel, ext, ld_res;

  assign off_q     = addr_q[OFFW-1:0];
  assign base_addr = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};

  always_comb begin
    be_mask = '0;
    case (f3_q[1:0])
      2'd0:    be_mask = (2*NB)'(8'h01);
      2'd1:    be_mask = (2*NB)'(8'h03);
      2'd2:    be_mask = (2*NB)'(8'h0F);
      default: be_mask = (2*NB)'(8'hFF);
    endcase
  end

  assign be_full = be_mask << off_q;
  assign w_full  = {{XLEN{1'b0}}, wdata_q} << {off_q, 3'b000};
  assign r_cat   = (state == BEAT1) ? {mem_rdata, rd0_q} : {{XLEN{1'b0}}, mem_rdata};
  assign sel     = XLEN'(r_cat >> {off_q, 3'b000});

  always_comb begin
    ext = '0;
    case (f3_q)
      3'b000:  ext = XLEN'($signed(sel[7:0]));
      3'b001:  ext = XLEN'($signed(sel[15:0]));
      3'b010:  ext = XLEN'($signed(sel[31:0]));
      3'b100:  ext = XLEN'(sel[7:0]);
      3'b101:  ext = XLEN'(sel[15:0]);
      3'b110:  ext = XLEN'(sel[31:0]);
      3'b011:  ext = sel;
      default: ext = '0;
    endcase
  end

  assign ld_res = we_q ? '0 : ext;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (req_valid) nxt = req_err ? RESP : BEAT0;
      BEAT0:   if (mem_ack)   nxt = spans_q ? BEAT1 : RESP;
      BEAT1:   if (mem_ack)   nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    case (state)
      BEAT0: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = base_addr;
        mem_be    = be_full[NB-1:0];
        mem_wdata = w_full[XLEN-1:0];
      end
      BEAT1: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = base_addr + XLEN'(NB);
        mem_be    = be_full[2*NB-1:NB];
        mem_wdata = w_full[2*XLEN-1:XLEN];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      spans_q     <= 1'b0;
      f3_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd0_q       <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (req_valid) begin
          we_q        <= req_we;
          f3_q        <= req_funct3;
          addr_q      <= req_addr;
          wdata_q     <= req_wdata;
          spans_q     <= req_spans;
          resp_err_q  <= req_err;
          resp_data_q <= '0;
        end
        BEAT0: if (mem_ack) begin
          rd0_q <= mem_rdata;
          if (!spans_q) resp_data_q <= ld_res;
        end
        BEAT1: if (mem_ack) resp_data_q <= ld_res;
        RESP: begin
          resp_data_q <= '0;
          resp_err_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign resp_valid = (state == RESP);
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
endmodule
